program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Bundles the loader's byte-link, memory-write and core-control signals.
// Ports: start/rx_data/rx_valid in to the loader; rx_ready, wr_en/wr_addr/wr_data,
//        cpu_hold/done/error out. slave = loader side, master = host/bench side.
interface program_loader_if #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         start;
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         rx_ready;
    logic                         wr_en;
    logic [PC_WIDTH-1:0]          wr_addr;
    logic [INSTRUCTION_WIDTH-1:0] wr_data;
    logic                         cpu_hold;
    logic                         done;
    logic                         error;

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Instruction-memory loader: length-prefixed, checksummed byte frame -> sequential word writes from addr 0.
// Latency: word write strobe one cycle after its last byte; done/error one cycle after the checksum byte.
// Backpressure: rx_ready high only while a frame is in progress; accepts one byte per clk with no stall.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries start, rx byte link, write port, cpu_hold/done/error.
module program_loader #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);
    localparam int          BYTES     = INSTRUCTION_WIDTH / 8;
    localparam int          BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned MAX_WORDS = 32'd1 << PC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [7:0]                   r_len_hi;
    logic [15:0]                  r_words_left;
    logic [BCW-1:0]               r_byte_cnt;
    logic [INSTRUCTION_WIDTH-1:0] r_word;
    logic [INSTRUCTION_WIDTH-1:0] r_wr_data;
    logic [PC_WIDTH-1:0]          r_wr_addr;
    logic                         r_wr_en;
    logic [7:0]                   r_sum;

    logic                         w_rx_ready;
    logic                         w_accept;
    logic [15:0]                  w_len;
    logic                         w_word_end;
    logic [INSTRUCTION_WIDTH-1:0] w_shifted;

    always_comb begin
        w_rx_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                     (r_state == S_DATA)   || (r_state == S_CHECK);
        w_accept   = w_rx_ready && bus.rx_valid;
        w_len      = {r_len_hi, bus.rx_data};
        w_word_end = (r_byte_cnt == BCW'(BYTES - 1));
        // Bytes arrive MSB first, so each new byte enters at the LSB end.
        w_shifted  = (r_word << 8) | INSTRUCTION_WIDTH'(bus.rx_data);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (32'(w_len) > MAX_WORDS) w_next = S_ERR;
                    else if (w_len == 16'd0)    w_next = S_CHECK;
                    else                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_word_end && (r_words_left == 16'd1)) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) w_next = (bus.rx_data == r_sum) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_hi     <= '0;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_wr_data    <= '0;
            r_wr_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_sum        <= '0;
        end else begin
            r_wr_en <= 1'b0;
            // Address moves on once the strobe cycle has presented it.
            if (r_wr_en) r_wr_addr <= r_wr_addr + PC_WIDTH'(1);
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_wr_addr    <= '0;
                        r_sum        <= '0;
                        r_byte_cnt   <= '0;
                        r_words_left <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) r_len_hi <= bus.rx_data;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_words_left <= w_len;
                        r_byte_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word <= w_shifted;
                        r_sum  <= r_sum + bus.rx_data;
                        if (w_word_end) begin
                            r_byte_cnt   <= '0;
                            r_wr_en      <= 1'b1;
                            r_wr_data    <= w_shifted;
                            r_words_left <= r_words_left - 16'd1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = w_rx_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cpu_hold = (r_state != S_DONE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.error    = (r_state == S_ERR);
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    localparam int PCW = 8;
    localparam int IW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_loader_if #(.PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW)) bus ();
    program_loader #(.PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Observed writes, {addr, data}, sampled mid-cycle.
    logic [39:0] got_wr[$];
    always @(negedge clk) if (bus.wr_en === 1'b1) got_wr.push_back({bus.wr_addr, bus.wr_data});

    // Reference expectations for the current frame.
    logic [39:0] exp_wr[$];
    bit          exp_done;
    bit          exp_err;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: parse length, assemble words MSB-first, sum payload mod 256.
    function automatic void model(input logic [7:0] fr[$]);
        int          n;
        int          sum;
        logic [31:0] word;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'(fr[0]) * 256 + int'(fr[1]);
        if (n > (1 << PCW)) begin
            exp_err = 1'b1;
            return;
        end
        sum = 0;
        for (int w = 0; w < n; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++) begin
                word = word * 256 + 32'(fr[2 + 4 * w + b]);
                sum  = sum + int'(fr[2 + 4 * w + b]);
            end
            exp_wr.push_back({8'(w), word});
        end
        if (int'(fr[2 + 4 * n]) == (sum % 256)) exp_done = 1'b1;
        else                                    exp_err  = 1'b1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ":rx_ready"}, bus.rx_ready, 0);
        check({tag, ":wr_en"},    bus.wr_en,    0);
        check({tag, ":wr_addr"},  bus.wr_addr,  0);
        check({tag, ":wr_data"},  bus.wr_data,  0);
        check({tag, ":cpu_hold"}, bus.cpu_hold, 1);
        check({tag, ":done"},     bus.done,     0);
        check({tag, ":error"},    bus.error,    0);
    endtask

    task automatic check_result(input string tag, input int stalls);
        check({tag, ":done"},     bus.done,     exp_done);
        check({tag, ":error"},    bus.error,    exp_err);
        check({tag, ":cpu_hold"}, bus.cpu_hold, !exp_done);
        check({tag, ":rx_ready"}, bus.rx_ready, 0);
        check({tag, ":stalls"},   stalls,       0);
        check({tag, ":wr_count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check({tag, ":wr_entry"}, got_wr[i], exp_wr[i]);
    endtask

    task automatic do_start(input string tag);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ":rdy_after_start"},  bus.rx_ready, 1);
        check({tag, ":done_after_start"}, bus.done,     0);
        check({tag, ":err_after_start"},  bus.error,    0);
    endtask

    // gap < 0: random 0..2 idle cycles before each byte; start_at: byte index whose first gap cycle pulses start.
    task automatic run_frame(input string tag, input logic [7:0] fr[$], input int gap, input int start_at);
        int stalls;
        int g;
        int bound;
        stalls = 0;
        model(fr);
        got_wr.delete();
        do_start(tag);
        for (int i = 0; i < fr.size(); i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i > 0) begin
                for (int k = 0; k < g; k++) begin
                    bus.rx_valid = 1'b0;
                    bus.start    = (i == start_at) && (k == 0);
                    tick();
                end
            end
            bus.start    = 1'b0;
            bus.rx_valid = 1'b1;
            bus.rx_data  = fr[i];
            bound = 0;
            while (bus.rx_ready !== 1'b1 && bound < 20) begin
                stalls++;
                bound++;
                tick();
            end
            tick();
        end
        bus.rx_valid = 1'b0;
        check_result(tag, stalls);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
    endtask

    logic [7:0] nf[$]  = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};
    logic [7:0] bad[$] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB9};
    logic [7:0] zf[$]  = '{8'h00, 8'h00, 8'h00};
    logic [7:0] of[$]  = '{8'h01, 8'h01};
    logic [7:0] rf[$];

    initial begin
        int n;
        int sum;
        logic [7:0] b;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Normal load with explicit write timing.
        model(nf);
        got_wr.delete();
        do_start("normal");
        send(8'h00); send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("normal:w0_en",   bus.wr_en,   1);
        check("normal:w0_addr", bus.wr_addr, 0);
        check("normal:w0_data", bus.wr_data, 32'h11223344);
        send(8'hAA);
        check("normal:w0_en_off",  bus.wr_en,   0);
        check("normal:addr_adv",   bus.wr_addr, 1);
        send(8'hBB); send(8'hCC); send(8'hDD);
        check("normal:w1_en",   bus.wr_en,   1);
        check("normal:w1_addr", bus.wr_addr, 1);
        check("normal:w1_data", bus.wr_data, 32'hAABBCCDD);
        send(8'hB8);
        bus.rx_valid = 1'b0;
        check_result("normal", 0);

        run_frame("badsum",  bad, 0, -1);
        run_frame("reload",  nf,  0, -1);
        run_frame("zero",    zf,  0, -1);
        run_frame("ovf",     of,  0, -1);
        run_frame("gapped",  nf,  3, 5);

        // Largest legal image fills the whole memory.
        rf.delete();
        rf.push_back(8'h01); rf.push_back(8'h00);
        sum = 0;
        for (int i = 0; i < 256 * 4; i++) begin
            b = 8'($urandom);
            rf.push_back(b);
            sum = sum + int'(b);
        end
        rf.push_back(8'(sum));
        run_frame("full", rf, 0, -1);

        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(0, 6));
            rf.delete();
            rf.push_back(8'h00); rf.push_back(8'(n));
            sum = 0;
            for (int i = 0; i < n * 4; i++) begin
                b = 8'($urandom);
                rf.push_back(b);
                sum = sum + int'(b);
            end
            if ($urandom_range(0, 1) == 0) sum = sum + int'($urandom_range(1, 255));
            rf.push_back(8'(sum));
            run_frame("random", rf, -1, -1);
        end

        // Reset in the middle of word 0.
        do_start("midrst");
        send(8'h00); send(8'h02); send(8'h11); send(8'h22);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        run_frame("after_rst", nf, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
